// File: rtl/bus_arbiter_4x1_pkg.sv
// Shared types and constants for the 4-requester bus arbiter.
package bus_arbiter_4x1_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    // Requester slots on the shared memory port
    localparam int unsigned REQ_IF  = 0;
    localparam int unsigned REQ_MEM = 1;
    localparam int unsigned REQ_VGA = 2;
    localparam int unsigned REQ_DMA = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Binary requester index to one-hot grant vector
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request scanning last+1, last+2, ... modulo 4.
module rr_pick4
    import bus_arbiter_4x1_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after last wins
    always_comb begin
        idx_o = '0;
        cand  = '0;
        any_o = |req_i;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            cand = last_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_4x1.sv
// Round-robin owner of the shared 32-bit slave port: grant, wait ready, ack, release.
module bus_arbiter_4x1
    import bus_arbiter_4x1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] lock_i,
    input  logic             slave_ready_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] sel_o,
    output logic             busy_o,
    output logic             slave_req_o,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] err_o
);

    localparam logic             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q,   sel_d;
    logic               busy_q,  busy_d;
    logic [N_REQ-1:0]   err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   last_q,  last_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               in_busy;
    logic               owner_req;
    logic               owner_lock;

    rr_pick4 u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign in_busy    = (state_q == ST_BUSY);
    assign owner_req  = req_i[sel_q];
    assign owner_lock = lock_i[sel_q];

    // Ack only for a still-requesting owner; a reset cycle completes nothing
    assign ack_o       = (in_busy && owner_req && slave_ready_i && !rst_i) ? grant_q : '0;
    assign slave_req_o = in_busy & (|(grant_q & req_i));

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

    // Next-state: arbitrate in IDLE, sequence abandon / ready / timeout in BUSY
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        err_d   = '0;
        cnt_d   = cnt_q;
        last_d  = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    grant_d = idx_onehot(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_req || (slave_ready_i && !owner_lock) ||
                    (!slave_ready_i && TO_EN && (cnt_q == TO_LAST))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    last_d  = sel_q;
                    if (owner_req && !slave_ready_i) begin
                        err_d = grant_q;
                    end
                end else if (slave_ready_i) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Structural invariants of the grant/ack/err outputs
    a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(grant_o)) else $error("grant not one-hot or zero");
    a_sel_matches   : assert property (@(posedge clk_i) disable iff (rst_i)
        busy_o |-> (grant_o == idx_onehot(sel_o))) else $error("sel disagrees with grant");
    a_ack_err_excl  : assert property (@(posedge clk_i)
        !((|ack_o) && (|err_o))) else $error("ack and err together");
    a_err_after_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (|err_o) |-> (!busy_o && $past(busy_o))) else $error("err outside BUSY exit");

endmodule
